// File: rtl/seq_1010_gen_if.sv
// Control and serial-output bundle between a burst requester and the 1010 frame generator.
interface seq_1010_gen_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [2:0]       gap;
  logic             abort;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, count, gap, abort,
    input  x, valid, busy, done, frames_sent
  );

  modport slave (
    input  start, count, gap, abort,
    output x, valid, busy, done, frames_sent
  );
endinterface

// File: rtl/seq_1010_gen.sv
// Burst generator: sends `count` copies of a 4-bit PATTERN MSB first,
// separated by `gap` idle cycles, with a one-cycle done pulse at the end.
module seq_1010_gen #(
  parameter logic [3:0]  PATTERN = 4'b1010,
  parameter int unsigned CNT_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  seq_1010_gen_if.slave  bus
);

  localparam int unsigned BIT_W = 2;
  localparam int unsigned GAP_W = 3;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   fs_q, fs_d;
  logic               x_q, x_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   fs_inc_c;

  assign fs_inc_c = fs_q + CNT_W'(1);

  // Next state and next registered outputs; each state's outputs describe the cycle it is entered for.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    gap_cnt_d = gap_cnt_q;
    count_d   = count_q;
    gap_d     = gap_q;
    fs_d      = fs_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.count != '0)) begin
          count_d = bus.count;
          gap_d   = bus.gap;
          fs_d    = '0;
          bit_d   = BIT_W'(3);
          state_d = SEND;
          x_d     = PATTERN[3];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (bit_q != '0) begin
          bit_d   = bit_q - BIT_W'(1);
          x_d     = PATTERN[bit_q - BIT_W'(1)];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          fs_d = fs_inc_c;
          if (fs_inc_c == count_q) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
            busy_d    = 1'b1;
          end else begin
            bit_d   = BIT_W'(3);
            x_d     = PATTERN[3];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
          bit_d   = BIT_W'(3);
          x_d     = PATTERN[3];
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort cancels an active burst silently, keeping the frame tally.
    if (bus.abort && ((state_q == SEND) || (state_q == GAP))) begin
      state_d = IDLE;
      fs_d    = fs_q;
      x_d     = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      gap_cnt_q <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      fs_q      <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      gap_cnt_q <= gap_cnt_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      fs_q      <= fs_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frames_sent = fs_q;

endmodule
